lynx_tap_player: RTL and testbench

//  Cassette-image player that sits upstream of the lynx48 EAR input.
//  - Captures a TAP image from the HPS ioctl download stream into on-chip RAM.
//  - On a play request, replays it as a square-wave EAR bitstream: leader tone, sync cycle, data bytes.
//  - Its ear_tap output is ORed at top level with the ADC tape input before it reaches lynx48.

---
 rtl/lynx_tap_pkg.sv | 17 +
 rtl/lynx_tap_ram.sv | 20 ++
 rtl/lynx_tap_player.sv | 197 +++++++++++++++++++
 tb/tb_lynx_tap_player.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/lynx_tap_pkg.sv
// rtl/lynx_tap_pkg.sv - shared types and default timing for the TAP cassette player
package lynx_tap_pkg;

  typedef enum logic [2:0] {IDLE, LEADER, SYNC, DATA, DONE} state_t;

  localparam int DEF_T0_HALF       = 2400;
  localparam int DEF_T1_HALF       = 1200;
  localparam int DEF_SYNC_HALF     = 3600;
  localparam int DEF_LEADER_CYCLES = 768;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/lynx_tap_ram.sv
// rtl/lynx_tap_ram.sv - simple dual-port byte RAM holding the TAP image, registered read
module lynx_tap_ram #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [7:0]        wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [7:0]        rdata_q
);

  logic [7:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata_q <= mem[raddr];
  end

endmodule

// File: rtl/lynx_tap_player.sv
// rtl/lynx_tap_player.sv - captures a TAP image from ioctl and replays it as an EAR square wave
module lynx_tap_player
  import lynx_tap_pkg::*;
#(
  parameter int ADDR_W        = 16,
  parameter int TAP_INDEX     = 1,
  parameter int T0_HALF       = DEF_T0_HALF,
  parameter int T1_HALF       = DEF_T1_HALF,
  parameter int SYNC_HALF     = DEF_SYNC_HALF,
  parameter int LEADER_CYCLES = DEF_LEADER_CYCLES
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_data,
  input  logic        play,
  input  logic        stop,
  output logic        ear_tap,
  output logic        active,
  output logic        done,
  output logic        overflow
);

  localparam int CNT_W = $clog2(max3(T0_HALF, T1_HALF, SYNC_HALF) + 1);
  localparam int CYC_W = $clog2(LEADER_CYCLES + 1);
  localparam logic [CNT_W-1:0] T0_LD   = CNT_W'(T0_HALF - 1);
  localparam logic [CNT_W-1:0] T1_LD   = CNT_W'(T1_HALF - 1);
  localparam logic [CNT_W-1:0] SYNC_LD = CNT_W'(SYNC_HALF - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              phase_q, phase_d;
  logic [CYC_W-1:0]  cyc_q, cyc_d;
  logic [2:0]        bit_q, bit_d;
  logic [ADDR_W:0]   byte_q, byte_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [7:0]        shift_q, shift_d;
  logic              overflow_q, overflow_d;
  logic              play_prev_q, play_prev_d;
  logic              dl_prev_q, dl_prev_d;
  logic [7:0]        rd_data;

  logic              tap_sel, dl_edge, wr_en, in_range, play_edge, playing;
  logic [ADDR_W:0]   wr_end;
  logic              unused_idx;

  assign tap_sel   = (ioctl_index[5:0] == 6'(TAP_INDEX));
  assign dl_edge   = ioctl_download & ~dl_prev_q & tap_sel;
  assign wr_en     = ioctl_download & ioctl_wr & tap_sel;
  assign in_range  = ((ioctl_addr >> ADDR_W) == 25'd0);
  assign wr_end    = {1'b0, ioctl_addr[ADDR_W-1:0]} + (ADDR_W+1)'(1);
  assign play_edge = play & ~play_prev_q;
  assign unused_idx = ^ioctl_index[7:6];

  lynx_tap_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk     (clk_sys),
    .we      (wr_en & in_range),
    .waddr   (ioctl_addr[ADDR_W-1:0]),
    .wdata   (ioctl_data),
    .raddr   (byte_q[ADDR_W-1:0]),
    .rdata_q (rd_data)
  );

  // Image length and overflow bookkeeping; a new matching download restarts both.
  always_comb begin
    play_prev_d = play;
    dl_prev_d   = ioctl_download;
    len_d       = dl_edge ? '0 : len_q;
    overflow_d  = dl_edge ? 1'b0 : overflow_q;
    if (wr_en) begin
      if (in_range) begin
        if (wr_end > len_d) len_d = wr_end;
      end else begin
        overflow_d = 1'b1;
      end
    end
  end

  // byte_q is the count of bytes already shifted out and doubles as the RAM read address.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    phase_d = phase_q;
    cyc_d   = cyc_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    shift_d = shift_q;
    case (state_q)
      IDLE: begin
        if (play_edge && len_q != '0 && !ioctl_download) begin
          state_d = LEADER;
          cnt_d   = T0_LD;
          phase_d = 1'b0;
          cyc_d   = '0;
        end
      end
      LEADER: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (!phase_q) begin
          phase_d = 1'b1;
          cnt_d   = T0_LD;
        end else if (cyc_q == CYC_W'(LEADER_CYCLES - 1)) begin
          state_d = SYNC;
          phase_d = 1'b0;
          cnt_d   = SYNC_LD;
          byte_d  = '0;
        end else begin
          cyc_d   = cyc_q + 1'b1;
          phase_d = 1'b0;
          cnt_d   = T0_LD;
        end
      end
      SYNC: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (!phase_q) begin
          phase_d = 1'b1;
          cnt_d   = SYNC_LD;
        end else begin
          state_d = DATA;
          phase_d = 1'b0;
          shift_d = rd_data;
          bit_d   = '0;
          byte_d  = (ADDR_W+1)'(1);
          cnt_d   = rd_data[7] ? T1_LD : T0_LD;
        end
      end
      DATA: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (!phase_q) begin
          phase_d = 1'b1;
          cnt_d   = shift_q[7] ? T1_LD : T0_LD;
        end else if (bit_q != 3'd7) begin
          phase_d = 1'b0;
          shift_d = {shift_q[6:0], 1'b0};
          bit_d   = bit_q + 1'b1;
          cnt_d   = shift_q[6] ? T1_LD : T0_LD;
        end else if (byte_q == len_q) begin
          state_d = DONE;
          phase_d = 1'b0;
        end else begin
          phase_d = 1'b0;
          shift_d = rd_data;
          bit_d   = '0;
          byte_d  = byte_q + 1'b1;
          cnt_d   = rd_data[7] ? T1_LD : T0_LD;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (state_q != IDLE && (stop || dl_edge)) begin
      state_d = IDLE;
      phase_d = 1'b0;
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      phase_q     <= 1'b0;
      cyc_q       <= '0;
      bit_q       <= '0;
      byte_q      <= '0;
      len_q       <= '0;
      shift_q     <= '0;
      overflow_q  <= 1'b0;
      play_prev_q <= 1'b0;
      dl_prev_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      phase_q     <= phase_d;
      cyc_q       <= cyc_d;
      bit_q       <= bit_d;
      byte_q      <= byte_d;
      len_q       <= len_d;
      shift_q     <= shift_d;
      overflow_q  <= overflow_d;
      play_prev_q <= play_prev_d;
      dl_prev_q   <= dl_prev_d;
    end
  end

  assign playing  = (state_q == LEADER) || (state_q == SYNC) || (state_q == DATA);
  assign ear_tap  = playing & ~phase_q;
  assign active   = playing;
  assign done     = (state_q == DONE);
  assign overflow = overflow_q;

endmodule

// File: tb/tb_lynx_tap_player.sv
// tb/tb_lynx_tap_player.sv - directed self-checking bench for lynx_tap_player
module tb_lynx_tap_player;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        ioctl_download = 1'b0;
  logic [7:0]  ioctl_index = 8'd0;
  logic        ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_data = '0;
  logic        play = 1'b0;
  logic        stop = 1'b0;
  logic        ear_tap, active, done, overflow;

  int total = 0;
  int bad = 0;
  logic [7:0] img [0:31];
  logic exp_q [$];

  lynx_tap_player #(
    .ADDR_W(4), .TAP_INDEX(1), .T0_HALF(4), .T1_HALF(8),
    .SYNC_HALF(6), .LEADER_CYCLES(2)
  ) dut (
    .clk_sys(clk_sys), .reset(reset), .ioctl_download(ioctl_download),
    .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
    .ioctl_data(ioctl_data), .play(play), .stop(stop), .ear_tap(ear_tap),
    .active(active), .done(done), .overflow(overflow)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_sys);
    #1;
  endtask

  task automatic add_half(input int h, input logic lvl);
    repeat (h) exp_q.push_back(lvl);
  endtask

  // Expected ear_tap level per cycle: 2 leader cycles, one sync cycle, then MSB-first bits.
  task automatic build(input int n);
    exp_q.delete();
    repeat (2) begin add_half(4, 1'b1); add_half(4, 1'b0); end
    add_half(6, 1'b1); add_half(6, 1'b0);
    for (int i = 0; i < n; i++)
      for (int b = 7; b >= 0; b--) begin
        add_half(img[i][b] ? 8 : 4, 1'b1);
        add_half(img[i][b] ? 8 : 4, 1'b0);
      end
  endtask

  task automatic download(input int n);
    ioctl_index = 8'd1;
    ioctl_download = 1'b1;
    tick();
    for (int i = 0; i < n; i++) begin
      ioctl_addr = 25'(i);
      ioctl_data = img[i];
      ioctl_wr = 1'b1;
      tick();
      ioctl_wr = 1'b0;
      tick();
    end
    ioctl_download = 1'b0;
    tick();
  endtask

  task automatic start_play;
    play = 1'b1;
    tick();
    play = 1'b0;
  endtask

  task automatic run(input string tag, input int count);
    for (int i = 0; i < count; i++) begin
      chk($sformatf("%s_c%0d", tag, i), {29'd0, ear_tap, active, done}, {29'd0, exp_q[i], 2'b10});
      tick();
    end
  endtask

  task automatic play_check(input string tag, input int n);
    start_play();
    build(n);
    run(tag, exp_q.size());
    chk({tag, "_done"}, {29'd0, ear_tap, active, done}, 32'd1);
    tick();
    chk({tag, "_idle"}, {29'd0, ear_tap, active, done}, 32'd0);
  endtask

  task automatic quiet(input string tag, input int count);
    for (int i = 0; i < count; i++) begin
      chk($sformatf("%s_q%0d", tag, i), {29'd0, ear_tap, active, done}, 32'd0);
      tick();
    end
  endtask

  initial begin
    #12;
    chk("reset_outs", {28'd0, ear_tap, active, done, overflow}, 32'd0);
    reset = 1'b0;
    tick();

    start_play();
    quiet("len0_play", 6);

    img[0] = 8'hA5;
    download(1);
    play_check("a5", 1);
    tick();
    play_check("a5_replay", 1);

    ioctl_index = 8'd2;
    ioctl_download = 1'b1;
    tick();
    start_play();
    quiet("dl_play", 6);
    ioctl_download = 1'b0;
    tick();

    for (int i = 0; i < 17; i++) img[i] = 8'(i * 37 + 3);
    download(17);
    chk("ovf_set", {31'd0, overflow}, 32'd1);
    play_check("len16", 16);

    img[0] = 8'hC3; img[1] = 8'h18; img[2] = 8'h7E;
    download(3);
    chk("ovf_clear", {31'd0, overflow}, 32'd0);
    play_check("len3", 3);

    start_play();
    build(3);
    run("stop_pre", 48);
    stop = 1'b1;
    tick();
    chk("stop_outs", {29'd0, ear_tap, active, done}, 32'd0);
    stop = 1'b0;
    tick();
    quiet("stop_after", 5);
    play_check("restart", 3);

    start_play();
    build(3);
    run("rst_pre", 20);
    #2 reset = 1'b1;
    #1 chk("async_rst", {28'd0, ear_tap, active, done, overflow}, 32'd0);
    @(posedge clk_sys);
    #1 reset = 1'b0;
    tick();
    start_play();
    quiet("rst_play", 6);

    img[0] = 8'h00; img[1] = 8'hFF;
    download(2);
    play_check("seam", 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
